rx_arbiter: RTL and testbench
=============================

# rx_arbiter

Round-robin input arbiter between the five per-direction rx deserialisers (north, east, south, west, local) and the router's single shared fifo. Each cycle it picks at most one valid rx item, acknowledges it with a one-cycle read pulse, and holds it in a one-entry output register. It then pushes that item into the fifo when the fifo is not full. It replaces fixed-priority input selection: no direction can starve, and the fifo write path is registered.

## Interface
Parameters:
- ITEM_W, default `HDR_SZ + `PL_SZ + `ADDR_SZ: width of one item in bits.
- NPORTS, default `DIRECTIONS (5): number of requesters. Port index order is 0 north, 1 east, 2 south, 3 west, 4 local.
- STALL_W, default 16: width of the stall counter.

Ports:
- Clocking and reset (already decided): one clock, `clk`; `reset` is synchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- valid  in  NPORTS  per-port item valid from the rx blocks.
- item  in  NPORTS*ITEM_W  per-port item. Port p occupies bits [p*ITEM_W +: ITEM_W].
- read  out  NPORTS  one-hot, combinational, single-cycle acknowledge to the granted rx.
- item_out  out  ITEM_W  output register contents, to fifo item_in.
- write  out  1  fifo write strobe.
- full  in  1  fifo full.
- grant_src  out  3  index of the port whose item is held in item_out.
- stall_count  out  STALL_W  saturating count of cycles in which a held item was blocked by full.

## Operation
State:
- out_valid: output register occupied.
- item_out and grant_src: registered item and its source port.
- ptr (0..NPORTS-1): round-robin search start.
- last_mask (NPORTS bits): one-hot of the previous cycle's grant, all-zero if there was none.
- stall_count.

Each cycle:
- write = out_valid & ~full.
- can_load = ~out_valid | ~full.
- eligible = valid & ~last_mask. The port granted in cycle t is masked in cycle t+1, because the rx still shows valid during the cycle after its read pulse.
- Winner w is the first eligible index searching ptr, ptr+1, … modulo NPORTS.
- grant = can_load & (eligible != 0) & ~reset.
- read[w] = grant; all other read bits are 0. read is 0 whenever grant is 0.

On the clock edge:
- If grant: item_out <= item[w], grant_src <= w, out_valid <= 1, ptr <= (w+1) mod NPORTS, last_mask <= onehot(w).
- Else: last_mask <= 0, ptr is unchanged, and out_valid <= out_valid & ~write.
- If out_valid & full: stall_count <= stall_count + 1, saturating at all-ones. stall_count is cleared only by reset.

Boundary and edge cases:
- Simultaneous write and grant (full=0, out_valid=1): the old item is written and the new item is loaded in the same cycle, with no bubble.
- full held high: out_valid stays 1, read stays 0, item_out is stable, and ptr is frozen.
- No eligible port: no grant and ptr is unchanged.
- ptr wrap-around: 4 -> 0.

## Timing
- Reset values (synchronous): out_valid=0, write=0, read=0, item_out=0, grant_src=0, ptr=0, last_mask=0, stall_count=0. During a reset cycle, read and write are forced to 0.
- Reset arriving mid-operation discards the held item; it is never written.
- Latency from valid to fifo write: 1 cycle minimum. A read pulse in cycle t gives write in cycle t+1 if full=0 then.
- Throughput: 1 item/cycle when two or more ports are active. A single active port gets at most 1 item per 2 cycles.
- All outputs except read are registered or registered-derived. write depends combinationally on full.

## Structure
- ITEM_W components (`HDR_SZ, `PL_SZ, `ADDR_SZ), `DIRECTIONS and the direction index constants belong in the shared defines include. They are not redefined locally.
- One natural sub-module: `rr_pick`, a combinational NPORTS-wide round-robin priority picker. Inputs are the eligible vector and ptr; outputs are a found flag and the winner index.
- Everything else is flat in rx_arbiter.

## Test plan
- Ports 0–4 all valid, full=0, held for 10 cycles -> read one-hot sequence is 0,1,2,3,4,0,1…, one grant per cycle. write=1 from the cycle after the first grant, and grant_src follows one cycle behind.
- Only port 2 valid, held continuously -> read[2] pulses on alternate cycles (mask). write=1 on the cycles between pulses.
- Grant port 1, then full=1 for 4 cycles -> write=0 and read=0 throughout, item_out stable, stall_count=4. Drop full -> write=1 that same cycle and port 2 is granted simultaneously.
- ptr=3, only ports 1 and 4 valid -> port 4 is granted first, then port 1. ptr ends at 2.
- out_valid=1, full=1, then reset asserted for 1 cycle -> next cycle out_valid=0, write=0, ptr=0, stall_count=0, and the held item is never written.
- Force full=1 with out_valid=1 for 65540 cycles -> stall_count saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/rx_arbiter_pkg.sv
// Shared router sizing defines plus the arbiter package: index width and the
// round-robin pointer advance helper used by rx_arbiter.
`ifndef ROUTER_DEFINES_SVH
`define ROUTER_DEFINES_SVH
`define HDR_SZ     8
`define PL_SZ      16
`define ADDR_SZ    8
`define DIRECTIONS 5
`define DIR_NORTH  0
`define DIR_EAST   1
`define DIR_SOUTH  2
`define DIR_WEST   3
`define DIR_LOCAL  4
`endif

package rx_arbiter_pkg;
    localparam int ITEM_W_DEF = `HDR_SZ + `PL_SZ + `ADDR_SZ;
    localparam int NPORTS_DEF = `DIRECTIONS;
    // Port indices and grant_src are 3 bits wide, enough for up to 8 requesters.
    localparam int IDX_W = 3;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w, input int nports);
        if (int'(w) == nports - 1) begin
            return '0;
        end
        return w + 1'b1;
    endfunction
endpackage

// File: rtl/rx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or after ptr,
// wrapping modulo NPORTS.
module rr_pick
    import rx_arbiter_pkg::*;
#(
    parameter int NPORTS = `DIRECTIONS
) (
    input  logic [NPORTS-1:0] eligible,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  winner
);

    int              idx;
    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest eligible port wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NPORTS) begin
                idx = idx - NPORTS;
            end
            cand = IDX_W'(idx);
            if (eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/rx_arbiter.sv
// Round-robin arbiter from the per-direction rx deserialisers into the shared
// fifo, with a one-entry registered output stage and a saturating stall counter.
module rx_arbiter
    import rx_arbiter_pkg::*;
#(
    parameter int ITEM_W  = `HDR_SZ + `PL_SZ + `ADDR_SZ,
    parameter int NPORTS  = `DIRECTIONS,
    parameter int STALL_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        valid,
    input  logic [NPORTS*ITEM_W-1:0] item,
    output logic [NPORTS-1:0]        read,
    output logic [ITEM_W-1:0]        item_out,
    output logic                     write,
    input  logic                     full,
    output logic [IDX_W-1:0]         grant_src,
    output logic [STALL_W-1:0]       stall_count
);

    logic                out_valid_q, out_valid_d;
    logic [ITEM_W-1:0]   item_out_q, item_out_d;
    logic [IDX_W-1:0]    grant_src_q, grant_src_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NPORTS-1:0]   last_mask_q, last_mask_d;
    logic [STALL_W-1:0]  stall_q, stall_d;

    logic                can_load;
    logic                grant;
    logic                found;
    logic [IDX_W-1:0]    winner;
    logic [NPORTS-1:0]   eligible;

    // The rx still shows valid the cycle after its read pulse, so last cycle's
    // grantee is excluded to avoid consuming the same item twice.
    assign eligible = valid & ~last_mask_q;
    assign write    = out_valid_q & ~full & ~reset;
    assign can_load = ~out_valid_q | ~full;
    assign grant    = can_load & found & ~reset;

    rr_pick #(
        .NPORTS (NPORTS)
    ) u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (found),
        .winner   (winner)
    );

    always_comb begin
        read = '0;
        if (grant) begin
            read[winner] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q & ~write;
        item_out_d  = item_out_q;
        grant_src_d = grant_src_q;
        ptr_d       = ptr_q;
        last_mask_d = '0;
        stall_d     = stall_q;
        if (grant) begin
            out_valid_d         = 1'b1;
            item_out_d          = item[int'(winner)*ITEM_W +: ITEM_W];
            grant_src_d         = winner;
            ptr_d               = next_ptr(winner, NPORTS);
            last_mask_d[winner] = 1'b1;
        end
        if (out_valid_q && full && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            item_out_q  <= '0;
            grant_src_q <= '0;
            ptr_q       <= '0;
            last_mask_q <= '0;
            stall_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            item_out_q  <= item_out_d;
            grant_src_q <= grant_src_d;
            ptr_q       <= ptr_d;
            last_mask_q <= last_mask_d;
            stall_q     <= stall_d;
        end
    end

    assign item_out    = item_out_q;
    assign grant_src   = grant_src_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_rx_arbiter.sv
// Directed bench for rx_arbiter: round-robin order, masking, full stalls,
// pointer wrap, mid-operation reset and stall counter saturation.
module tb_rx_arbiter;
    import rx_arbiter_pkg::*;

    localparam int ITEM_W  = ITEM_W_DEF;
    localparam int NPORTS  = NPORTS_DEF;
    localparam int STALL_W = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NPORTS-1:0]        valid;
    logic [NPORTS*ITEM_W-1:0] item;
    logic [NPORTS-1:0]        read;
    logic [ITEM_W-1:0]        item_out;
    logic                     write;
    logic                     full;
    logic [IDX_W-1:0]         grant_src;
    logic [STALL_W-1:0]       stall_count;

    int checks = 0;
    int errors = 0;
    logic [ITEM_W-1:0] exp_q[$];

    rx_arbiter #(
        .ITEM_W  (ITEM_W),
        .NPORTS  (NPORTS),
        .STALL_W (STALL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .item        (item),
        .read        (read),
        .item_out    (item_out),
        .write       (write),
        .full        (full),
        .grant_src   (grant_src),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [ITEM_W-1:0] item_of(input int p);
        return ITEM_W'(32'hA5C3_0000 + p * 32'h111);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = '0;
        full  = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic check_write_item(input string tag);
        logic [ITEM_W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(item_out), 64'(e));
        end
    endtask

    initial begin
        for (int p = 0; p < NPORTS; p++) begin
            item[p*ITEM_W +: ITEM_W] = item_of(p);
        end
        reset = 1'b1;
        valid = '0;
        full  = 1'b0;

        // Reset state
        do_reset();
        sample();
        check("rst_read", 64'(read), 64'd0);
        check("rst_write", 64'(write), 64'd0);
        check("rst_item_out", 64'(item_out), 64'd0);
        check("rst_grant_src", 64'(grant_src), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        next_cycle();

        // All ports valid: one grant per cycle in order 0..4, writes trail by one
        do_reset();
        valid = 5'b11111;
        for (int k = 0; k < 10; k++) begin
            sample();
            check("rr_read", 64'(read), 64'(5'b00001 << (k % 5)));
            check("rr_write", 64'(write), 64'(k >= 1));
            if (k >= 1) begin
                check("rr_grant_src", 64'(grant_src), 64'((k - 1) % 5));
                check_write_item("rr_item");
            end
            exp_q.push_back(item_of(k % 5));
            next_cycle();
        end
        valid = '0;
        sample();
        check("rr_drain_read", 64'(read), 64'd0);
        check("rr_drain_write", 64'(write), 64'd1);
        check_write_item("rr_drain_item");
        next_cycle();
        sample();
        check("rr_idle_write", 64'(write), 64'd0);
        check("rr_queue_left", 64'(exp_q.size()), 64'd0);
        next_cycle();

        // Single port 2: grant on alternate cycles, write in between
        do_reset();
        valid = 5'b00100;
        for (int k = 0; k < 8; k++) begin
            sample();
            check("solo_read", 64'(read), (k % 2 == 0) ? 64'h4 : 64'h0);
            check("solo_write", 64'(write), 64'(k % 2 == 1));
            next_cycle();
        end

        // Grant port 1, then 4 cycles of full, then release with port 2 waiting
        do_reset();
        valid = 5'b00010;
        sample();
        check("stall_first_read", 64'(read), 64'h2);
        next_cycle();
        full  = 1'b1;
        valid = 5'b00110;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("stall_write", 64'(write), 64'd0);
            check("stall_read", 64'(read), 64'd0);
            check("stall_item", 64'(item_out), 64'(item_of(1)));
            check("stall_src", 64'(grant_src), 64'd1);
            check("stall_count_run", 64'(stall_count), 64'(k));
            next_cycle();
        end
        full  = 1'b0;
        valid = 5'b00100;
        sample();
        check("stall_count4", 64'(stall_count), 64'd4);
        check("release_write", 64'(write), 64'd1);
        check("release_item", 64'(item_out), 64'(item_of(1)));
        check("release_read", 64'(read), 64'h4);
        next_cycle();
        valid = '0;
        sample();
        check("release_src2", 64'(grant_src), 64'd2);
        check("release_item2", 64'(item_out), 64'(item_of(2)));
        check("release_write2", 64'(write), 64'd1);
        next_cycle();

        // ptr=3 with ports 1 and 4 valid: 4 first, then 1, leaving ptr at 2
        do_reset();
        valid = 5'b00100;
        sample();
        check("wrap_setup_read", 64'(read), 64'h4);
        next_cycle();
        valid = 5'b10010;
        sample();
        check("wrap_read4", 64'(read), 64'h10);
        next_cycle();
        sample();
        check("wrap_read1", 64'(read), 64'h2);
        check("wrap_src4", 64'(grant_src), 64'd4);
        next_cycle();
        valid = 5'b11111;
        sample();
        check("wrap_ptr2", 64'(read), 64'h4);
        check("wrap_src1", 64'(grant_src), 64'd1);
        next_cycle();

        // Reset while an item is held behind full discards it
        do_reset();
        valid = 5'b00001;
        sample();
        check("mid_rst_grant", 64'(read), 64'h1);
        next_cycle();
        valid = '0;
        full  = 1'b1;
        next_cycle();
        reset = 1'b1;
        valid = 5'b11111;
        sample();
        check("mid_rst_read", 64'(read), 64'd0);
        check("mid_rst_write", 64'(write), 64'd0);
        check("mid_rst_stall_before", 64'(stall_count), 64'd1);
        next_cycle();
        reset = 1'b0;
        full  = 1'b0;
        valid = '0;
        sample();
        check("post_rst_write", 64'(write), 64'd0);
        check("post_rst_stall", 64'(stall_count), 64'd0);
        check("post_rst_item", 64'(item_out), 64'd0);
        next_cycle();
        valid = 5'b11111;
        sample();
        check("post_rst_ptr0", 64'(read), 64'h1);
        next_cycle();

        // Stall counter saturation
        do_reset();
        valid = 5'b00001;
        next_cycle();
        valid = '0;
        full  = 1'b1;
        repeat (65534) next_cycle();
        sample();
        check("sat_fffe", 64'(stall_count), 64'hFFFE);
        next_cycle();
        sample();
        check("sat_ffff", 64'(stall_count), 64'hFFFF);
        repeat (5) next_cycle();
        sample();
        check("sat_hold", 64'(stall_count), 64'hFFFF);
        check("sat_write", 64'(write), 64'd0);
        check("sat_item", 64'(item_out), 64'(item_of(0)));
        next_cycle();
        full = 1'b0;
        sample();
        check("sat_release_write", 64'(write), 64'd1);
        check("sat_release_stall", 64'(stall_count), 64'hFFFF);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
